instr_encoder: RTL and testbench

Sequential RV32I instruction encoder and program loader. It accepts decoded instruction fields over a valid/ready request port. It packs each request into a 32-bit word using the opcode and field layout our `Controller` decodes: R_TYPE, I_TYPE, LW, SW, BR, JAL and JALR. It then writes the words to consecutive instruction-memory addresses through a registered write port. It sits in the test/boot path ahead of instruction memory and produces the instruction stream the core's decoder consumes.

---
 rtl/instr_encoder_pkg.sv | 33 +++
 rtl/instr_encoder_if.sv | 34 +++
 rtl/instr_encoder_pack.sv | 60 ++++++
 rtl/instr_encoder.sv | 115 +++++++++++
 tb/tb_instr_encoder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
//   op_kind_e : request operation kind as carried on req_op
//   opcodes   : 7-bit major opcodes, identical to the Controller's decode table
//   state_e   : loader FSM states
package instr_enc_pkg;

  typedef enum logic [2:0] {
    OP_R    = 3'd0,
    OP_I    = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BR   = 3'd4,
    OP_JAL  = 3'd5,
    OP_JALR = 3'd6,
    OP_RSVD = 3'd7
  } op_kind_e;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Request + instruction-memory write bundle of the encoder.
//   req_*     : decoded instruction fields with valid/ready handshake
//   mem_*     : registered write port with mem_ready back-pressure
// slave  = encoder side, master = requester / memory side.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [2:0]        req_funct3;
  logic              req_alt;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              req_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport slave (
    input  req_valid, req_op, req_funct3, req_alt, req_rd, req_rs1, req_rs2,
           req_imm, req_last, mem_ready,
    output req_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_funct3, req_alt, req_rd, req_rs1, req_rs2,
           req_imm, req_last, mem_ready,
    input  req_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: decoded fields -> 32-bit RV32I word + reject.
//   op_i/funct3_i/alt_i/rd_i/rs1_i/rs2_i/imm_i : request fields
//   word_o   : encoded instruction
//   reject_o : immediate out of range, misaligned BR/JAL target, or reserved op
module instr_pack
  import instr_enc_pkg::*;
(
  input  op_kind_e    op_i,
  input  logic [2:0]  funct3_i,
  input  logic        alt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        reject_o
);
  logic       fits12, fits13, fits21;
  logic [6:0] imm_hi;

  always_comb begin
    // A value fits in N signed bits when bits [31:N-1] are all equal.
    fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);
    // slli/srli/srai carry the alt bit in funct7 instead of imm[11:5].
    imm_hi = (funct3_i[1:0] == 2'b01) ? {1'b0, alt_i, 5'b0} : imm_i[11:5];
    word_o   = '0;
    reject_o = 1'b0;
    case (op_i)
      OP_R:    word_o = {1'b0, alt_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, R_TYPE};
      OP_I: begin
        word_o   = {imm_hi, imm_i[4:0], rs1_i, funct3_i, rd_i, I_TYPE};
        reject_o = ~fits12;
      end
      OP_LW: begin
        word_o   = {imm_i[11:0], rs1_i, 3'b010, rd_i, LW};
        reject_o = ~fits12;
      end
      OP_SW: begin
        word_o   = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], SW};
        reject_o = ~fits12;
      end
      OP_BR: begin
        word_o   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                    imm_i[4:1], imm_i[11], BR};
        reject_o = ~fits13 | imm_i[0];
      end
      OP_JAL: begin
        word_o   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, JAL};
        reject_o = ~fits21 | imm_i[0];
      end
      OP_JALR: begin
        word_o   = {imm_i[11:0], rs1_i, 3'b000, rd_i, JALR};
        reject_o = ~fits12;
      end
      default: reject_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder / program loader.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a session (honoured in IDLE or DONE)
//   bus        : request channel in, memory write channel out
//   busy/done  : registered decodes of RUN|DRAIN and DONE
//   err        : sticky, some request of this session was rejected
//   count      : words accepted for writing this session
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);
  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  state_e              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [31:0]         word;
  logic                reject, accept, wr, fire;

  instr_pack u_pack (
    .op_i     (op_kind_e'(bus.req_op)),
    .funct3_i (bus.req_funct3),
    .alt_i    (bus.req_alt),
    .rd_i     (bus.req_rd),
    .rs1_i    (bus.req_rs1),
    .rs2_i    (bus.req_rs2),
    .imm_i    (bus.req_imm),
    .word_o   (word),
    .reject_o (reject)
  );

  // One-deep output register: a new word may enter in the same cycle the
  // held one drains.
  assign bus.req_ready = (state_q == S_RUN) & (~mem_we_q | bus.mem_ready);
  assign accept = bus.req_valid & bus.req_ready;
  assign wr     = accept & ~reject;
  assign fire   = mem_we_q & bus.mem_ready;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    err_d       = err_q;
    if (fire) begin
      mem_we_d = 1'b0;
      // Hold at the top address after the final write rather than wrapping.
      if (mem_addr_q != '1) mem_addr_d = mem_addr_q + 1'b1;
    end
    if (wr) begin
      mem_we_d    = 1'b1;
      mem_wdata_d = word;
      count_d     = count_q + 1'b1;
    end
    if (accept & reject) err_d = 1'b1;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d    = S_RUN;
        mem_addr_d = '0;
        count_d    = '0;
        err_d      = 1'b0;
      end
      S_RUN:   if (accept & (bus.req_last | (wr & (count_q == LAST_CNT)))) state_d = S_DRAIN;
      S_DRAIN: if (!mem_we_d) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) | (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign count = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, start2 = 1'b0;
  logic busy, done, err, busy2, done2, err2;
  logic [8:0] count;
  logic [2:0] count2;

  int n_checks = 0;
  int n_fail = 0;

  wr_t obs_q[$], obs2_q[$], exp_q[$];
  int  exp_addr;
  bit  exp_err;
  bit  rnd_stop;

  instr_encoder_if #(.ADDR_W(8)) bus ();
  instr_encoder_if #(.ADDR_W(2)) bus2 ();

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus.slave),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bus(bus2.slave),
    .busy(busy2), .done(done2), .err(err2), .count(count2)
  );

  always #5 clk = ~clk;

  // Write loggers: record every completed memory write.
  always @(negedge clk) begin
    if (!reset && bus.mem_we && bus.mem_ready) obs_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (!reset && bus2.mem_we && bus2.mem_ready) obs2_q.push_back({6'd0, bus2.mem_addr, bus2.mem_wdata});
  end

  // Reference encoder built from the instruction formats with plain arithmetic.
  function automatic void model(input int op, input int f3, input int alt, input int rd,
                                input int rs1, input int rs2, input int imm,
                                output logic [31:0] w, output bit rej);
    logic [31:0] ib, hi;
    ib = imm;
    w = 0;
    rej = 0;
    case (op)
      0: w = (alt << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1: begin
        hi = (f3 == 1 || f3 == 5) ? ((alt << 10) | (ib & 32'h1f)) : (ib & 32'hfff);
        w = (hi << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        rej = imm < -2048 || imm > 2047;
      end
      2: begin
        w = ((ib & 32'hfff) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
        rej = imm < -2048 || imm > 2047;
      end
      3: begin
        w = (((ib >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
          | ((ib & 32'h1f) << 7) | 32'h23;
        rej = imm < -2048 || imm > 2047;
      end
      4: begin
        w = (((ib >> 12) & 1) << 31) | (((ib >> 5) & 32'h3f) << 25) | (rs2 << 20) | (rs1 << 15)
          | (f3 << 12) | (((ib >> 1) & 32'hf) << 8) | (((ib >> 11) & 1) << 7) | 32'h63;
        rej = imm < -4096 || imm > 4095 || (imm % 2 != 0);
      end
      5: begin
        w = (((ib >> 20) & 1) << 31) | (((ib >> 1) & 32'h3ff) << 21) | (((ib >> 11) & 1) << 20)
          | (((ib >> 12) & 32'hff) << 12) | (rd << 7) | 32'h6f;
        rej = imm < -(1 << 20) || imm >= (1 << 20) || (imm % 2 != 0);
      end
      6: begin
        w = ((ib & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
        rej = imm < -2048 || imm > 2047;
      end
      default: rej = 1;
    endcase
  endfunction

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    obs_q.delete();
    exp_q.delete();
    exp_addr = 0;
    exp_err = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int op, input int f3, input int alt, input int rd,
                      input int rs1, input int rs2, input int imm, input int last);
    int n = 0;
    logic [31:0] w;
    bit rej;
    bus.req_op = op[2:0]; bus.req_funct3 = f3[2:0]; bus.req_alt = alt[0];
    bus.req_rd = rd[4:0]; bus.req_rs1 = rs1[4:0]; bus.req_rs2 = rs2[4:0];
    bus.req_imm = imm; bus.req_last = last[0]; bus.req_valid = 1'b1;
    model(op, f3, alt, rd, rs1, rs2, imm, w, rej);
    if (rej) exp_err = 1;
    else begin
      exp_q.push_back({exp_addr[7:0], w});
      exp_addr++;
    end
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept_timeout: req_ready=%b required 1 op=%0d", bus.req_ready, op);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_last = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done=%b required 1", name, done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, count, err, busy, done, bus.req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b addr=%h wdata=%h count=%0d err=%b busy=%b done=%b ready=%b required all 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, count, err, busy, done, bus.req_ready);
    end
    n_checks++;
    if ({bus2.mem_we, count2, busy2, done2, bus2.req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs2: we=%b count=%0d busy=%b done=%b ready=%b required all 0",
               bus2.mem_we, count2, busy2, done2, bus2.req_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] ref_w [3] = '{32'h00500093, 32'h002081B3, 32'h402081B3};
    do_start();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: busy=%b required 1", busy); end
    send(1, 0, 0, 1, 0, 0, 5, 0);
    send(0, 0, 0, 3, 1, 2, 0, 0);
    send(0, 0, 1, 3, 1, 2, 0, 1);
    wait_done("basic");
    n_checks++;
    if (obs_q.size() != 3) begin n_fail++; $display("FAIL basic_nwrites: got %0d required 3", obs_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_q[i].data !== ref_w[i] || obs_q[i].addr !== 8'(i)) begin
        n_fail++;
        $display("FAIL basic_word%0d: got %h@%0d required %h@%0d", i, obs_q[i].data, obs_q[i].addr, ref_w[i], i);
      end
    end
    n_checks++;
    if (count !== 9'd3 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: count=%0d err=%b busy=%b required 3 0 0", count, err, busy);
    end
  endtask

  task automatic test_mem_ops();
    logic [31:0] ref_w [3] = '{32'h00812283, 32'h00512623, 32'h00008067};
    do_start();
    send(2, 0, 0, 5, 2, 0, 8, 0);
    send(3, 0, 0, 0, 2, 5, 12, 0);
    send(6, 0, 0, 0, 1, 0, 0, 1);
    wait_done("memops");
    n_checks++;
    if (obs_q.size() != 3) begin n_fail++; $display("FAIL memops_nwrites: got %0d required 3", obs_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_q[i].data !== ref_w[i] || obs_q[i].addr !== 8'(i)) begin
        n_fail++;
        $display("FAIL memops_word%0d: got %h@%0d required %h@%0d", i, obs_q[i].data, obs_q[i].addr, ref_w[i], i);
      end
    end
  endtask

  task automatic test_branch_reject();
    logic [31:0] ref_w [2] = '{32'hFE208CE3, 32'h010000EF};
    do_start();
    send(4, 0, 0, 0, 1, 2, -8, 0);
    send(5, 0, 0, 1, 0, 0, 16, 0);
    send(4, 0, 0, 0, 1, 2, -7, 1);
    wait_done("branch");
    n_checks++;
    if (obs_q.size() != 2) begin n_fail++; $display("FAIL branch_nwrites: got %0d required 2", obs_q.size()); end
    else for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs_q[i].data !== ref_w[i] || obs_q[i].addr !== 8'(i)) begin
        n_fail++;
        $display("FAIL branch_word%0d: got %h@%0d required %h@%0d", i, obs_q[i].data, obs_q[i].addr, ref_w[i], i);
      end
    end
    n_checks++;
    if (err !== 1'b1 || bus.mem_addr !== 8'd2 || count !== 9'd2 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_reject: err=%b addr=%0d count=%0d we=%b required 1 2 2 0",
               err, bus.mem_addr, count, bus.mem_we);
    end
  endtask

  task automatic test_stall();
    do_start();
    send(1, 0, 0, 1, 0, 0, 1, 0);
    bus.mem_ready = 1'b0;
    fork
      send(0, 0, 0, 2, 1, 1, 0, 0);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          n_checks++;
          if (bus.mem_we !== 1'b1 || bus.mem_addr !== exp_q[0].addr || bus.mem_wdata !== exp_q[0].data
              || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold%0d: we=%b addr=%0d wdata=%h ready=%b required 1 %0d %h 0",
                     c, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.req_ready, exp_q[0].addr, exp_q[0].data);
          end
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
      end
    join
    send(1, 4, 0, 3, 2, 0, -1, 1);
    wait_done("stall");
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stall_nwrites: got %0d required %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_word%0d: got %h@%0d required %h@%0d", i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
      end
    end
  endtask

  task automatic test_random();
    do_start();
    rnd_stop = 0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          int op, imm;
          op = ($urandom_range(0, 11) == 0) ? 7 : int'($urandom_range(0, 6));
          case ($urandom_range(0, 2))
            0: imm = int'($urandom_range(0, 4095)) - 2048;
            1: imm = int'($urandom_range(0, 16383)) - 8192;
            default: imm = int'($urandom_range(0, 32'h3FFFFF)) - 32'sh200000;
          endcase
          if ($urandom_range(0, 1) == 1) imm = imm & ~1;
          send(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm, (k == 39) ? 1 : 0);
        end
        rnd_stop = 1;
      end
      begin
        while (!rnd_stop) begin
          @(posedge clk); #1;
          bus.mem_ready = ($urandom_range(0, 3) != 0);
        end
        bus.mem_ready = 1'b1;
      end
    join
    wait_done("random");
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random_nwrites: got %0d required %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_word%0d: got %h@%0d required %h@%0d", i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
      end
    end
    n_checks++;
    if (err !== exp_err || count !== 9'(exp_addr)) begin
      n_fail++;
      $display("FAIL random_status: err=%b count=%0d required %b %0d", err, count, exp_err, exp_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    bus.mem_ready = 1'b0;
    send(1, 0, 0, 7, 0, 0, 3, 0);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending: we=%b required 1", bus.mem_we); end
    @(negedge clk);
    n_checks++;
    if ({bus.mem_we, bus.mem_addr, count, err, busy, done, bus.req_ready} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: we=%b addr=%0d count=%0d err=%b busy=%b done=%b ready=%b required all 0",
               bus.mem_we, bus.mem_addr, count, err, busy, done, bus.req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    do_start();
    send(0, 0, 0, 4, 1, 2, 0, 1);
    wait_done("rstmid");
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL rstmid_restart: nwrites=%0d first=%h required 1 write %h@0",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_capacity();
    wr_t exp2[$];
    @(posedge clk); #1;
    start2 = 1'b1;
    obs2_q.delete();
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int n = 0;
      logic [31:0] w;
      bit rej;
      bus2.req_op = 3'd0; bus2.req_funct3 = 3'd0; bus2.req_alt = 1'b0;
      bus2.req_rd = 5'(i + 1); bus2.req_rs1 = 5'(i); bus2.req_rs2 = 5'(i + 2);
      bus2.req_imm = '0; bus2.req_last = 1'b0; bus2.req_valid = 1'b1;
      model(0, 0, 0, i + 1, i, i + 2, 0, w, rej);
      @(negedge clk);
      while (!bus2.req_ready && n < 8) begin @(negedge clk); n++; end
      n_checks++;
      if (bus2.req_ready !== (i < 4)) begin
        n_fail++;
        $display("FAIL cap_ready%0d: req_ready=%b required %b", i, bus2.req_ready, i < 4);
      end
      if (bus2.req_ready) begin
        exp2.push_back({8'(i), w});
        @(posedge clk); #1;
      end
      bus2.req_valid = 1'b0;
    end
    for (int n = 0; n < 20 && done2 !== 1'b1; n++) @(negedge clk);
    n_checks++;
    if (done2 !== 1'b1 || err2 !== 1'b0 || count2 !== 3'd4) begin
      n_fail++;
      $display("FAIL cap_status: done=%b err=%b count=%0d required 1 0 4", done2, err2, count2);
    end
    n_checks++;
    if (obs2_q.size() != 4) begin n_fail++; $display("FAIL cap_nwrites: got %0d required 4", obs2_q.size()); end
    else foreach (exp2[i]) begin
      n_checks++;
      if (obs2_q[i] !== exp2[i]) begin
        n_fail++;
        $display("FAIL cap_word%0d: got %h@%0d required %h@%0d", i, obs2_q[i].data, obs2_q[i].addr, exp2[i].data, exp2[i].addr);
      end
    end
  endtask

  initial begin
    bus.req_valid = 0; bus.req_op = 0; bus.req_funct3 = 0; bus.req_alt = 0;
    bus.req_rd = 0; bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_imm = 0;
    bus.req_last = 0; bus.mem_ready = 1;
    bus2.req_valid = 0; bus2.req_op = 0; bus2.req_funct3 = 0; bus2.req_alt = 0;
    bus2.req_rd = 0; bus2.req_rs1 = 0; bus2.req_rs2 = 0; bus2.req_imm = 0;
    bus2.req_last = 0; bus2.mem_ready = 1;
    test_reset();
    test_basic();
    test_mem_ops();
    test_branch_reject();
    test_stall();
    test_random();
    test_reset_mid();
    test_capacity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
